// File: rtl/crossbar_out_arbiter.sv
// Per-output-port scheduler: round-robin grant among crossbar points, AXI-Stream mux of the
// grantee onto the output link, release on last beat or on a start timeout.
module crossbar_out_arbiter #(
  parameter int unsigned P_NUM_SRC = 8,
  parameter logic [15:0] P_TIMEOUT = 16'd255,
  parameter int unsigned P_SEL_W   = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [P_NUM_SRC-1:0]     i_trans_req,
  output logic [P_NUM_SRC-1:0]     o_trans_grant,
  input  logic [P_NUM_SRC-1:0]     s_axis_tvalid,
  input  logic [64*P_NUM_SRC-1:0]  s_axis_tdata,
  input  logic [P_NUM_SRC-1:0]     s_axis_tlast,
  input  logic [8*P_NUM_SRC-1:0]   s_axis_tkeep,
  output logic [P_NUM_SRC-1:0]     s_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [63:0]              m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [7:0]               m_axis_tkeep,
  output logic                     m_axis_tuser,
  input  logic                     m_axis_tready,
  output logic [P_SEL_W-1:0]       o_sel,
  output logic                     o_busy,
  output logic [15:0]              o_timeout_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [P_NUM_SRC-1:0] L_ONE = {{(P_NUM_SRC-1){1'b0}}, 1'b1};

  state_t              state;
  logic [P_SEL_W-1:0]  r_last;
  logic [15:0]         r_wait_cnt;

  logic                any_req;
  logic [P_SEL_W-1:0]  next_sel;
  logic [P_SEL_W-1:0]  scan_idx;
  logic                hs;
  logic                sel_tlast;
  logic                active;

  logic [63:0]         src_data [P_NUM_SRC];
  logic [7:0]          src_keep [P_NUM_SRC];

  for (genvar g = 0; g < P_NUM_SRC; g++) begin : g_unpack
    assign src_data[g] = s_axis_tdata[64*g +: 64];
    assign src_keep[g] = s_axis_tkeep[8*g +: 8];
  end

  // Round-robin pick: first requester at or after r_last+1, wrapping.
  always_comb begin
    any_req  = 1'b0;
    next_sel = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < P_NUM_SRC; i++) begin
      scan_idx = P_SEL_W'((32'(r_last) + 32'd1 + 32'(i)) % P_NUM_SRC);
      if (!any_req && i_trans_req[scan_idx]) begin
        any_req  = 1'b1;
        next_sel = scan_idx;
      end
    end
  end

  assign active    = (state == GRANT) || (state == BUSY);
  assign hs        = s_axis_tvalid[o_sel] & m_axis_tready;
  assign sel_tlast = s_axis_tlast[o_sel];

  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tkeep  = '1;
    s_axis_tready = '0;
    if (active) begin
      m_axis_tvalid        = s_axis_tvalid[o_sel];
      m_axis_tdata         = src_data[o_sel];
      m_axis_tlast         = s_axis_tlast[o_sel];
      m_axis_tkeep         = src_keep[o_sel];
      s_axis_tready[o_sel] = m_axis_tready;
    end
  end

  assign m_axis_tuser = 1'b0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      o_trans_grant <= '0;
      o_sel         <= '0;
      r_last        <= P_SEL_W'(P_NUM_SRC - 1);
      o_busy        <= 1'b0;
      o_timeout_cnt <= '0;
      r_wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            o_sel         <= next_sel;
            o_trans_grant <= L_ONE << next_sel;
            r_wait_cnt    <= '0;
            o_busy        <= 1'b1;
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (hs) begin
            if (sel_tlast) begin
              o_trans_grant <= '0;
              o_busy        <= 1'b0;
              state         <= RELEASE;
            end else begin
              state <= BUSY;
            end
          end else if (r_wait_cnt == P_TIMEOUT - 16'd1) begin
            o_trans_grant <= '0;
            o_busy        <= 1'b0;
            if (o_timeout_cnt != 16'hffff) o_timeout_cnt <= o_timeout_cnt + 16'd1;
            state         <= RELEASE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        BUSY: begin
          if (hs && sel_tlast) begin
            o_trans_grant <= '0;
            o_busy        <= 1'b0;
            state         <= RELEASE;
          end
        end
        RELEASE: begin
          r_last <= o_sel;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
